pid_steer_pipe: RTL



---
 rtl/pid_steer_pipe.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pid_steer_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pid_steer_pipe
//  Description : Pipelined PID steering controller for the line-follower
//                drivetrain. Converts a signed line-position error into
//                left/right unsigned motor speed commands around a ramped
//                forward speed.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1        system clock, rising edge
//    rst_n          in   1        asynchronous active-low reset
//    error          in   ERR_W    signed line error (valid with err_vld)
//    err_vld        in   1        single-cycle new-sample strobe
//    go             in   1        run enable; low clears the controller
//    line_present   in   1        line detected by the sensor front end
//    p_coeff        in   COEF_W   unsigned proportional gain
//    i_coeff        in   COEF_W   unsigned integral gain
//    d_coeff        in   COEF_W   unsigned derivative gain
//    lft_speed      out  SPD_W    left motor command
//    rght_speed     out  SPD_W    right motor command
//    moving         out  1        forward speed above MOVE_THRESH
//    pid_vld        out  1        pulse: new PID output takes effect
//    frwrd          out  SPD_W-1  current forward speed
// ============================================================================
module pid_steer_pipe #(
  parameter int ERR_W       = 16,
  parameter int SAT_W       = 11,
  parameter int DSAT_W      = 8,
  parameter int COEF_W      = 7,
  parameter int SPD_W       = 12,
  parameter int RAMP_STEP   = 4,
  parameter int MAX_FRWRD   = 'h300,
  parameter int MOVE_THRESH = 'h080,
  parameter int D_DLY       = 2,
  parameter int I_SHIFT     = 6,
  parameter int OUT_SHIFT   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [ERR_W-1:0]  error,
  input  logic                     err_vld,
  input  logic                     go,
  input  logic                     line_present,
  input  logic [COEF_W-1:0]        p_coeff,
  input  logic [COEF_W-1:0]        i_coeff,
  input  logic [COEF_W-1:0]        d_coeff,
  output logic [SPD_W-1:0]         lft_speed,
  output logic [SPD_W-1:0]         rght_speed,
  output logic                     moving,
  output logic                     pid_vld,
  output logic [SPD_W-2:0]         frwrd
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int FW    = SPD_W - 1;            // forward speed width
  localparam int FW1   = FW + 1;               // forward speed plus carry
  localparam int SUM_W = SAT_W + COEF_W + 2;   // saturated PID sum width
  localparam int WIDE  = SUM_W + 2;            // unsaturated sum headroom
  localparam int PID_W = SUM_W - OUT_SHIFT;    // shifted PID result width
  localparam int IW    = ERR_W - I_SHIFT;      // integrator bits fed to I term
  localparam int PT_W  = COEF_W + 1 + SAT_W;   // P product width
  localparam int IT_W  = COEF_W + 1 + IW;      // I product width
  localparam int DT_W  = COEF_W + 1 + DSAT_W;  // D product width
  localparam int OW    = ((PID_W > FW) ? PID_W : FW) + 2;  // speed arithmetic

  localparam logic [FW-1:0]  MAX_F  = FW'(MAX_FRWRD);
  localparam logic [FW1-1:0] MAX_F1 = FW1'(MAX_FRWRD);
  localparam logic [FW-1:0]  MOVE_T = FW'(MOVE_THRESH);
  localparam logic [FW1-1:0] STEP   = FW1'(RAMP_STEP);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic signed [SAT_W-1:0]  hist [D_DLY];
  logic signed [ERR_W-1:0]  integ;
  logic signed [SAT_W-1:0]  err_s1;
  logic signed [DSAT_W-1:0] diff_s1;
  logic                     vld_s1;
  logic signed [PID_W-1:0]  pid_s;
  logic                     pid_vld_r;
  logic [FW-1:0]            frwrd_r;
  logic                     line_d;

  // --------------------------------------------------------------------------
  // Error saturation: in range only when every bit above the SAT_W sign
  // position matches the ERR_W sign bit.
  // --------------------------------------------------------------------------
  logic signed [SAT_W-1:0] err_sat;

  always_comb begin
    err_sat = error[SAT_W-1:0];
    if (!error[ERR_W-1] && (|error[ERR_W-2:SAT_W-1])) begin
      err_sat = {1'b0, {(SAT_W-1){1'b1}}};
    end else if (error[ERR_W-1] && !(&error[ERR_W-2:SAT_W-1])) begin
      err_sat = {1'b1, {(SAT_W-1){1'b0}}};
    end
  end

  // --------------------------------------------------------------------------
  // Derivative: current sample minus the oldest history entry, clamped.
  // --------------------------------------------------------------------------
  logic signed [SAT_W:0]    diff;
  logic signed [DSAT_W-1:0] diff_sat;

  assign diff = {err_sat[SAT_W-1], err_sat}
              - {hist[D_DLY-1][SAT_W-1], hist[D_DLY-1]};

  always_comb begin
    diff_sat = diff[DSAT_W-1:0];
    if (!diff[SAT_W] && (|diff[SAT_W-1:DSAT_W-1])) begin
      diff_sat = {1'b0, {(DSAT_W-1){1'b1}}};
    end else if (diff[SAT_W] && !(&diff[SAT_W-1:DSAT_W-1])) begin
      diff_sat = {1'b1, {(DSAT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D_DLY; k++) hist[k] <= '0;
    end else if (!go) begin
      for (int k = 0; k < D_DLY; k++) hist[k] <= '0;
    end else if (err_vld) begin
      hist[0] <= err_sat;
      for (int k = 1; k < D_DLY; k++) hist[k] <= hist[k-1];
    end
  end

  // --------------------------------------------------------------------------
  // Integrator: one extra bit catches overflow, which then clamps.
  // --------------------------------------------------------------------------
  logic                    line_rise;
  logic                    integ_clr;
  logic signed [ERR_W:0]   integ_sum;
  logic signed [ERR_W-1:0] integ_next;

  assign line_rise = line_present & ~line_d;
  assign integ_clr = line_rise | ~go | ~moving;
  assign integ_sum = {integ[ERR_W-1], integ}
                   + {{(ERR_W+1-SAT_W){err_sat[SAT_W-1]}}, err_sat};

  always_comb begin
    integ_next = integ_sum[ERR_W-1:0];
    if (integ_sum[ERR_W] != integ_sum[ERR_W-1]) begin
      integ_next = integ_sum[ERR_W] ? {1'b1, {(ERR_W-1){1'b0}}}
                                    : {1'b0, {(ERR_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_d <= 1'b0;
      integ  <= '0;
    end else begin
      line_d <= line_present;
      if (integ_clr) begin
        integ <= '0;
      end else if (err_vld) begin
        integ <= integ_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_s1  <= '0;
      diff_s1 <= '0;
      vld_s1  <= 1'b0;
    end else if (!go) begin
      err_s1  <= '0;
      diff_s1 <= '0;
      vld_s1  <= 1'b0;
    end else begin
      vld_s1 <= err_vld;
      if (err_vld) begin
        err_s1  <= err_sat;
        diff_s1 <= diff_sat;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: products, saturated sum, arithmetic shift
  // --------------------------------------------------------------------------
  logic signed [COEF_W:0]   p_s;
  logic signed [COEF_W:0]   i_s;
  logic signed [COEF_W:0]   d_s;
  logic signed [IW-1:0]     integ_hi;
  logic signed [PT_W-1:0]   p_term;
  logic signed [IT_W-1:0]   i_term;
  logic signed [DT_W-1:0]   d_term;
  logic signed [WIDE-1:0]   sum_wide;
  logic signed [SUM_W-1:0]  sum_sat;
  logic signed [PID_W-1:0]  pid_next;

  // Coefficients are unsigned gains; a zero MSB keeps them positive.
  assign p_s      = $signed({1'b0, p_coeff});
  assign i_s      = $signed({1'b0, i_coeff});
  assign d_s      = $signed({1'b0, d_coeff});
  assign integ_hi = integ[ERR_W-1:I_SHIFT];

  assign p_term   = PT_W'(p_s) * PT_W'(err_s1);
  assign i_term   = IT_W'(i_s) * IT_W'(integ_hi);
  assign d_term   = DT_W'(d_s) * DT_W'(diff_s1);
  assign sum_wide = WIDE'(p_term) + WIDE'(i_term) + WIDE'(d_term);

  always_comb begin
    sum_sat = sum_wide[SUM_W-1:0];
    if (!sum_wide[WIDE-1] && (|sum_wide[WIDE-2:SUM_W-1])) begin
      sum_sat = {1'b0, {(SUM_W-1){1'b1}}};
    end else if (sum_wide[WIDE-1] && !(&sum_wide[WIDE-2:SUM_W-1])) begin
      sum_sat = {1'b1, {(SUM_W-1){1'b0}}};
    end
  end

  // Arithmetic right shift of a signed value is its upper bits.
  assign pid_next = sum_sat[SUM_W-1:OUT_SHIFT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_s     <= '0;
      pid_vld_r <= 1'b0;
    end else if (!go) begin
      pid_s     <= '0;
      pid_vld_r <= 1'b0;
    end else begin
      pid_vld_r <= vld_s1;
      if (vld_s1) begin
        pid_s <= pid_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Forward speed ramp
  // --------------------------------------------------------------------------
  logic [FW1-1:0] frwrd_up_raw;
  logic [FW-1:0]  frwrd_up;
  logic [FW-1:0]  frwrd_dn;

  assign frwrd_up_raw = {1'b0, frwrd_r} + STEP;
  assign frwrd_up     = (frwrd_up_raw > MAX_F1) ? MAX_F : frwrd_up_raw[FW-1:0];
  assign frwrd_dn     = ({1'b0, frwrd_r} >= STEP) ? (frwrd_r - STEP[FW-1:0]) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frwrd_r <= '0;
    end else if (!go) begin
      frwrd_r <= '0;
    end else if (err_vld) begin
      frwrd_r <= line_present ? frwrd_up : frwrd_dn;
    end
  end

  assign moving = (frwrd_r > MOVE_T);
  assign frwrd  = frwrd_r;

  // --------------------------------------------------------------------------
  // Speed outputs: forward speed +/- steering, clamped to 0..2^SPD_W-1
  // --------------------------------------------------------------------------
  function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [OW-1:0] v);
    if (v[OW-1]) begin
      return '0;
    end else if (|v[OW-2:SPD_W]) begin
      return '1;
    end else begin
      return v[SPD_W-1:0];
    end
  endfunction

  logic signed [OW-1:0] f_ext;
  logic signed [OW-1:0] pid_ext;
  logic signed [OW-1:0] lft_raw;
  logic signed [OW-1:0] rght_raw;

  assign f_ext    = OW'($signed({1'b0, frwrd_r}));
  assign pid_ext  = OW'(pid_s);
  assign lft_raw  = f_ext + pid_ext;
  assign rght_raw = f_ext - pid_ext;

  assign lft_speed  = moving ? clamp_spd(lft_raw)  : {1'b0, frwrd_r};
  assign rght_speed = moving ? clamp_spd(rght_raw) : {1'b0, frwrd_r};
  assign pid_vld    = pid_vld_r;

  // Integrator fraction and shifted-out sum bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{integ[I_SHIFT-1:0], sum_sat[OUT_SHIFT-1:0]};

endmodule
`default_nettype wire
